// File: rtl/dsp_mac_pipe_sim.sv
// -----------------------------------------------------------------------------
// dsp_mac_pipe_sim
// Simulation model of the QLF K6N10F DSP slice: signed/unsigned multiply with a
// configurable multiplier pipeline, valid tracking, multiply-accumulate modes
// and a rounding right-shift on the output.
//
// Optional feature macro: DSP_MAC_SAT_EN
//   defined     -> a mode-1 accumulator overflow clamps to max/min
//   not defined -> the accumulator wraps modulo 2^ACC_WIDTH
//
// Ports:
//   clock_i        clock, all state on rising edge
//   reset_i        synchronous active-high reset
//   valid_i        input sample valid
//   a_i, b_i       operands A (A_WIDTH) and B (B_WIDTH)
//   unsigned_a_i   1 = A unsigned
//   unsigned_b_i   1 = B unsigned
//   mode_i         0 mul, 1 accumulate, 2 load, 3 hold
//   shift_right_i  output right-shift amount
//   round_i        round half-up before the shift
//   z_o            result (low Z_WIDTH bits)
//   valid_o        z_o updated this cycle
//   overflow_o     accumulator overflowed on the sample at z_o
// -----------------------------------------------------------------------------
module dsp_mac_pipe_sim #(
  parameter int A_WIDTH     = 20,
  parameter int B_WIDTH     = 18,
  parameter int ACC_WIDTH   = 64,
  parameter int Z_WIDTH     = 38,
  parameter int PIPE_STAGES = 1,
  parameter int REG_INPUTS  = 1
) (
  input  logic               clock_i,
  input  logic               reset_i,
  input  logic               valid_i,
  input  logic [A_WIDTH-1:0] a_i,
  input  logic [B_WIDTH-1:0] b_i,
  input  logic               unsigned_a_i,
  input  logic               unsigned_b_i,
  input  logic [1:0]         mode_i,
  input  logic [5:0]         shift_right_i,
  input  logic               round_i,
  output logic [Z_WIDTH-1:0] z_o,
  output logic               valid_o,
  output logic               overflow_o
);

  localparam int PW = A_WIDTH + B_WIDTH;
  // control word: [11] valid, [10] unsigned A, [9] unsigned B,
  //               [8:7] mode, [6:1] shift, [0] round
  localparam int CW = 12;

  function automatic logic [ACC_WIDTH-1:0] round_shift(
    input logic [ACC_WIDTH-1:0] v,
    input logic [5:0]           sh,
    input logic                 rnd,
    input logic                 both_u
  );
    logic [ACC_WIDTH-1:0] t;
    t = v;
    if (rnd && (sh != 6'd0))
      t = v + (ACC_WIDTH'(1) << (sh - 6'd1));
    if (both_u)
      return t >> sh;
    else
      return $signed(t) >>> sh;
  endfunction

`ifdef DSP_MAC_SAT_EN
  // Unsigned overflow can only be a carry upward; signed overflow goes toward
  // the sign both addends share, which is the sign of the old accumulator.
  function automatic logic [ACC_WIDTH-1:0] sat_value(input logic both_u, input logic neg);
    if (both_u)
      return {ACC_WIDTH{1'b1}};
    else if (neg)
      return {1'b1, {(ACC_WIDTH-1){1'b0}}};
    else
      return {1'b0, {(ACC_WIDTH-1){1'b1}}};
  endfunction
`endif

  logic [CW-1:0]      w_ctrl_in;
  logic [A_WIDTH-1:0] w_a_p0;
  logic [B_WIDTH-1:0] w_b_p0;
  logic [CW-1:0]      w_ctrl_p0;

  assign w_ctrl_in = {valid_i, unsigned_a_i, unsigned_b_i, mode_i, shift_right_i, round_i};

  // ---- input stage (p0) ----
  if (REG_INPUTS != 0) begin : g_in_reg
    logic [A_WIDTH-1:0] r_a_p0;
    logic [B_WIDTH-1:0] r_b_p0;
    logic [CW-1:0]      r_ctrl_p0;
    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        r_a_p0    <= '0;
        r_b_p0    <= '0;
        r_ctrl_p0 <= '0;
      end else begin
        r_a_p0    <= a_i;
        r_b_p0    <= b_i;
        r_ctrl_p0 <= w_ctrl_in;
      end
    end
    assign w_a_p0    = r_a_p0;
    assign w_b_p0    = r_b_p0;
    assign w_ctrl_p0 = r_ctrl_p0;
  end else begin : g_in_comb
    assign w_a_p0    = a_i;
    assign w_b_p0    = b_i;
    assign w_ctrl_p0 = w_ctrl_in;
  end

  // The exact product of the extended operands always fits in PW bits, so a
  // PW-bit multiply loses nothing for any signedness combination.
  logic signed [PW-1:0] w_a_ext;
  logic signed [PW-1:0] w_b_ext;
  logic signed [PW-1:0] w_prod_p0;

  always_comb begin
    if (w_ctrl_p0[10]) w_a_ext = PW'(w_a_p0);
    else               w_a_ext = PW'($signed(w_a_p0));
    if (w_ctrl_p0[9])  w_b_ext = PW'(w_b_p0);
    else               w_b_ext = PW'($signed(w_b_p0));
    w_prod_p0 = w_a_ext * w_b_ext;
  end

  // ---- multiplier pipeline (p1) ----
  logic [CW+PW-1:0] w_pd_p0;
  logic [CW+PW-1:0] w_pd_p1;
  assign w_pd_p0 = {w_ctrl_p0, w_prod_p0};

  if (PIPE_STAGES == 0) begin : g_pipe_none
    assign w_pd_p1 = w_pd_p0;
  end else begin : g_pipe
    logic [CW+PW-1:0] r_pipe_p1 [PIPE_STAGES];
    always_ff @(posedge clock_i) begin
      if (reset_i) begin
        for (int i = 0; i < PIPE_STAGES; i++) r_pipe_p1[i] <= '0;
      end else begin
        r_pipe_p1[0] <= w_pd_p0;
        for (int i = 1; i < PIPE_STAGES; i++) r_pipe_p1[i] <= r_pipe_p1[i-1];
      end
    end
    assign w_pd_p1 = r_pipe_p1[PIPE_STAGES-1];
  end

  // ---- accumulator / output stage (p2) ----
  logic [CW-1:0]               w_ctrl_p1;
  logic signed [PW-1:0]        w_prod_p1;
  logic                        w_vld_p1;
  logic                        w_both_u;
  logic [1:0]                  w_mode_p1;
  logic signed [ACC_WIDTH-1:0] w_pext;
  logic [ACC_WIDTH:0]          w_sum_x;
  logic [ACC_WIDTH-1:0]        w_sum;
  logic                        w_ovf;
  logic [ACC_WIDTH-1:0]        w_acc_mac;
  logic [ACC_WIDTH-1:0]        w_result;

  logic [ACC_WIDTH-1:0] r_acc_p2;
  logic [Z_WIDTH-1:0]   r_z_p2;
  logic                 r_vld_p2;
  logic                 r_ovf_p2;

  assign w_ctrl_p1 = w_pd_p1[CW+PW-1:PW];
  assign w_prod_p1 = w_pd_p1[PW-1:0];
  assign w_vld_p1  = w_ctrl_p1[11];
  assign w_both_u  = w_ctrl_p1[10] & w_ctrl_p1[9];
  assign w_mode_p1 = w_ctrl_p1[8:7];

  always_comb begin
    if (w_both_u) w_pext = ACC_WIDTH'($unsigned(w_prod_p1));
    else          w_pext = ACC_WIDTH'(w_prod_p1);
    w_sum_x = {1'b0, r_acc_p2} + {1'b0, w_pext};
    w_sum   = w_sum_x[ACC_WIDTH-1:0];
    if (w_both_u)
      w_ovf = w_sum_x[ACC_WIDTH];
    else
      w_ovf = (r_acc_p2[ACC_WIDTH-1] == w_pext[ACC_WIDTH-1]) &&
              (w_sum[ACC_WIDTH-1] != r_acc_p2[ACC_WIDTH-1]);
`ifdef DSP_MAC_SAT_EN
    w_acc_mac = w_ovf ? sat_value(w_both_u, r_acc_p2[ACC_WIDTH-1]) : w_sum;
`else
    w_acc_mac = w_sum;
`endif
    if (w_mode_p1 == 2'd1) w_result = w_acc_mac;
    else                   w_result = w_pext;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_acc_p2 <= '0;
      r_z_p2   <= '0;
      r_vld_p2 <= 1'b0;
      r_ovf_p2 <= 1'b0;
    end else begin
      r_vld_p2 <= 1'b0;
      if (w_vld_p1 && (w_mode_p1 != 2'd3)) begin
        r_vld_p2 <= 1'b1;
        r_z_p2   <= Z_WIDTH'(round_shift(w_result, w_ctrl_p1[6:1], w_ctrl_p1[0], w_both_u));
        r_ovf_p2 <= (w_mode_p1 == 2'd1) && w_ovf;
      end
      if (w_vld_p1) begin
        case (w_mode_p1)
          2'd1:    r_acc_p2 <= w_acc_mac;
          2'd2:    r_acc_p2 <= w_pext;
          default: r_acc_p2 <= r_acc_p2;
        endcase
      end
    end
  end

  assign z_o        = r_z_p2;
  assign valid_o    = r_vld_p2;
  assign overflow_o = r_ovf_p2;

endmodule

// File: tb/tb_dsp_mac_pipe_sim.sv
module tb_dsp_mac_pipe_sim;

  logic        clk = 1'b0;
  logic        rst;
  logic        vld;
  logic [19:0] a;
  logic [17:0] b;
  logic        ua, ub;
  logic [1:0]  mode;
  logic [5:0]  sh;
  logic        rnd;

  logic [37:0] z0, z1;
  logic        v0, v1, o0, o1;

  int n_cmp  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  // default configuration
  dsp_mac_pipe_sim u_d0 (
    .clock_i(clk), .reset_i(rst), .valid_i(vld), .a_i(a), .b_i(b),
    .unsigned_a_i(ua), .unsigned_b_i(ub), .mode_i(mode),
    .shift_right_i(sh), .round_i(rnd),
    .z_o(z0), .valid_o(v0), .overflow_o(o0)
  );

  // 40-bit accumulator for overflow behaviour
  dsp_mac_pipe_sim #(.ACC_WIDTH(40)) u_d1 (
    .clock_i(clk), .reset_i(rst), .valid_i(vld), .a_i(a), .b_i(b),
    .unsigned_a_i(ua), .unsigned_b_i(ub), .mode_i(mode),
    .shift_right_i(sh), .round_i(rnd),
    .z_o(z1), .valid_o(v1), .overflow_o(o1)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [19:0] ia, input logic [17:0] ib,
                       input logic iua, input logic iub, input logic [1:0] im,
                       input logic [5:0] ish, input logic ir);
    vld  = 1'b1;
    a    = ia;
    b    = ib;
    ua   = iua;
    ub   = iub;
    mode = im;
    sh   = ish;
    rnd  = ir;
  endtask

  // One isolated sample; returns once its result is visible (3-cycle latency).
  task automatic push(input logic [19:0] ia, input logic [17:0] ib,
                      input logic iua, input logic iub, input logic [1:0] im,
                      input logic [5:0] ish, input logic ir);
    drive(ia, ib, iua, iub, im, ish, ir);
    step();
    vld = 1'b0;
    step();
    chk("latency_early", 64'(v0), 64'd0);
    step();
  endtask

  logic [19:0] qa [24];
  logic [17:0] qb [24];
  longint      p;
  longint      pk;
  logic [39:0] w40;

  initial begin
    rst = 1'b1; vld = 1'b0; a = '0; b = '0; ua = 1'b0; ub = 1'b0;
    mode = 2'd0; sh = 6'd0; rnd = 1'b0;
    step();
    step();
    rst = 1'b0;
    chk("reset_z", 64'(z0), 64'd0);
    chk("reset_valid", 64'(v0), 64'd0);
    chk("reset_ovf", 64'(o0), 64'd0);

    // streaming signed multiply, continuous valid
    for (int i = 0; i < 24; i++) begin
      qa[i] = 20'($urandom);
      qb[i] = 18'($urandom);
    end
    qa[0] = 20'h80000; qb[0] = 18'h20000;
    qa[1] = 20'h7FFFF; qb[1] = 18'h20000;
    for (int c = 0; c < 27; c++) begin
      if (c >= 3) begin
        p = longint'($signed(qa[c-3])) * longint'($signed(qb[c-3]));
        chk("stream_valid", 64'(v0), 64'd1);
        chk("stream_z", 64'(z0), 64'(p[37:0]));
      end
      if (c < 24) drive(qa[c], qb[c], 1'b0, 1'b0, 2'd0, 6'd0, 1'b0);
      else        vld = 1'b0;
      step();
    end

    // load / accumulate / bubble / hold
    push(20'd3, 18'd4, 1'b0, 1'b0, 2'd2, 6'd0, 1'b0);
    chk("load_z", 64'(z0), 64'd12);
    chk("load_ovf", 64'(o0), 64'd0);
    push(20'(-2), 18'd5, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0);
    chk("acc1_z", 64'(z0), 64'd2);
    step();
    chk("bubble_valid", 64'(v0), 64'd0);
    chk("bubble_hold_z", 64'(z0), 64'd2);
    push(20'd7, 18'd1, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0);
    chk("acc2_z", 64'(z0), 64'd9);
    chk("acc2_valid", 64'(v0), 64'd1);
    push(20'd100, 18'd100, 1'b0, 1'b0, 2'd3, 6'd0, 1'b0);
    chk("hold_valid", 64'(v0), 64'd0);
    chk("hold_z", 64'(z0), 64'd9);
    push(20'd1, 18'd1, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0);
    chk("after_hold_z", 64'(z0), 64'd10);

    // unsigned vs signed interpretation of all-ones operands
    push(20'hFFFFF, 18'h3FFFF, 1'b1, 1'b1, 2'd0, 6'd0, 1'b0);
    chk("unsigned_z", 64'(z0), 64'h3F_FFEC_0001);
    push(20'hFFFFF, 18'h3FFFF, 1'b0, 1'b0, 2'd0, 6'd0, 1'b0);
    chk("signed_z", 64'(z0), 64'd1);

    // rounding shift
    push(20'd7, 18'd1, 1'b0, 1'b0, 2'd0, 6'd1, 1'b1);
    chk("round_up_z", 64'(z0), 64'd4);
    push(20'd7, 18'd1, 1'b0, 1'b0, 2'd0, 6'd1, 1'b0);
    chk("trunc_z", 64'(z0), 64'd3);
    push(20'(-7), 18'd1, 1'b0, 1'b0, 2'd0, 6'd1, 1'b1);
    chk("round_neg_z", 64'(z0), 64'h3F_FFFF_FFFD);

    // overflow on the 40-bit accumulator
    p = longint'(20'h7FFFF) * longint'(18'h1FFFF);
    push(20'h7FFFF, 18'h1FFFF, 1'b0, 1'b0, 2'd2, 6'd0, 1'b0);
    chk("ovf_load_z", 64'(z1), 64'(p[37:0]));
    chk("ovf_load_flag", 64'(o1), 64'd0);
    for (int k = 2; k <= 9; k++) begin
      push(20'h7FFFF, 18'h1FFFF, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0);
      pk  = p * longint'(k);
      w40 = pk[39:0];
      chk("ovf_acc64_z", 64'(z0), 64'(pk[37:0]));
      chk("ovf_acc64_flag", 64'(o0), 64'd0);
      chk("ovf_acc40_flag", 64'(o1), (k == 9) ? 64'd1 : 64'd0);
      if (k < 9) begin
        chk("ovf_acc40_z", 64'(z1), 64'(w40[37:0]));
      end else begin
`ifdef DSP_MAC_SAT_EN
        chk("ovf_sat_z", 64'(z1), 64'h3F_FFFF_FFFF);
`else
        chk("ovf_wrap_z", 64'(z1), 64'(w40[37:0]));
`endif
      end
    end
    push(20'd2, 18'd3, 1'b0, 1'b0, 2'd2, 6'd0, 1'b0);
    chk("ovf_clear_flag", 64'(o1), 64'd0);
    chk("ovf_clear_z", 64'(z1), 64'd6);
    push(20'd1, 18'd1, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0);
    chk("acc_before_reset", 64'(z0), 64'd7);

    // reset with samples in flight
    drive(20'd1000, 18'd1000, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0);
    step();
    drive(20'd2000, 18'd2000, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0);
    step();
    drive(20'd3000, 18'd3000, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0);
    rst = 1'b1;
    step();
    rst = 1'b0;
    vld = 1'b0;
    chk("rst_flight_valid", 64'(v0), 64'd0);
    chk("rst_flight_z", 64'(z0), 64'd0);
    chk("rst_flight_ovf", 64'(o0), 64'd0);
    chk("rst_flight_z40", 64'(z1), 64'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("rst_discard_valid", 64'(v0), 64'd0);
    end
    push(20'(-2), 18'd5, 1'b0, 1'b0, 2'd1, 6'd0, 1'b0);
    chk("rst_acc_zero_z", 64'(z0), 64'h3F_FFFF_FFF6);
    chk("rst_acc_zero_valid", 64'(v0), 64'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
